btb_ctrl: RTL and testbench

//  Sequencer for an array of N branch-target-buffer entries sharing one op/data bus.

---
 rtl/btb_ctrl.sv | 173 +++++++++++++++++
 tb/tb_btb_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// Branch-target-buffer sequencer: muxes entry lookups into a fetch prediction,
// turns resolved branches into one VERIFY/INSERT op and runs full-array clear sweeps.
module btb_ctrl #(
    parameter int N_ENTRIES = 4,
    parameter int IDX_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              fetch_pc,
    output logic                     pred_hit,
    output logic                     pred_taken,
    output logic [15:0]              pred_target,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [15:0]              res_pc,
    input  logic                     res_taken,
    input  logic [15:0]              res_target,
    input  logic                     clr_req,
    output logic                     busy,
    output logic [N_ENTRIES-1:0]     ent_en,
    output logic [2:0]               ent_op,
    output logic [15:0]              ent_pc,
    output logic [11:0]              ent_in_pc,
    output logic [15:0]              ent_in_target,
    input  logic [N_ENTRIES-1:0]     ent_hit,
    input  logic [N_ENTRIES-1:0]     ent_pred,
    input  logic [16*N_ENTRIES-1:0]  ent_target,
    input  logic [N_ENTRIES-1:0]     ent_empty
);

    // Resolution handshake: a branch transfers on a cycle where res_valid and
    // res_ready are both high; the source must hold res_valid and res_* until then.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    localparam logic [2:0] OP_IDLE    = 3'b000;
    localparam logic [2:0] OP_CLEAR   = 3'b001;
    localparam logic [2:0] OP_LOOKUP  = 3'b100;
    localparam logic [2:0] OP_VFY_FT  = 3'b010;
    localparam logic [2:0] OP_VFY_TGT = 3'b011;
    localparam logic [2:0] OP_INS_FT  = 3'b110;
    localparam logic [2:0] OP_INS_TGT = 3'b111;

    localparam logic [N_ENTRIES-1:0] EN_ONE   = {{(N_ENTRIES-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_ENTRIES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clr_pend_q, clr_pend_d;
    logic [15:0]      res_pc_q, res_pc_d;
    logic             res_taken_q, res_taken_d;
    logic [15:0]      res_target_q, res_target_d;

    logic             hit_any, empty_any;
    logic [IDX_W-1:0] hit_idx, empty_idx, victim_idx;
    logic [15:0]      sel_target;
    logic             sel_pred;

    // Lowest-index priority: scan downward so the lowest set bit wins.
    always_comb begin
        hit_any   = |ent_hit;
        empty_any = |ent_empty;
        hit_idx   = '0;
        empty_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (ent_hit[i])   hit_idx   = IDX_W'(i);
            if (ent_empty[i]) empty_idx = IDX_W'(i);
        end
        sel_target = '0;
        sel_pred   = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (IDX_W'(i) == hit_idx) begin
                sel_target = ent_target[16*i +: 16];
                sel_pred   = ent_pred[i];
            end
        end
        victim_idx = hit_any ? hit_idx : (empty_any ? empty_idx : rr_ptr_q);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        clr_idx_d    = clr_idx_q;
        clr_pend_d   = clr_pend_q;
        res_pc_d     = res_pc_q;
        res_taken_d  = res_taken_q;
        res_target_d = res_target_q;
        pred_hit     = 1'b0;
        pred_taken   = 1'b0;
        pred_target  = '0;
        res_ready    = 1'b0;
        ent_en       = '0;
        ent_op       = OP_IDLE;
        ent_pc       = fetch_pc;

        case (state_q)
            S_IDLE: begin
                ent_op      = OP_LOOKUP;
                pred_hit    = hit_any;
                pred_taken  = sel_pred & hit_any;
                pred_target = sel_target;
                res_ready   = ~clr_req;
                if (clr_req) begin
                    state_d    = S_CLEAR;
                    clr_idx_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (res_valid) begin
                    res_pc_d     = res_pc;
                    res_taken_d  = res_taken;
                    res_target_d = res_target;
                    state_d      = S_UPDATE;
                end
            end
            S_UPDATE: begin
                ent_pc = res_pc_q;
                ent_en = EN_ONE << victim_idx;
                if (hit_any) ent_op = res_taken_q ? OP_VFY_TGT : OP_VFY_FT;
                else         ent_op = res_taken_q ? OP_INS_TGT : OP_INS_FT;
                if (!hit_any && !empty_any) rr_ptr_d = rr_ptr_q + 1'b1;
                clr_pend_d = clr_pend_q | clr_req;
                // The update always completes; a clear seen here runs right after it.
                if (clr_pend_q | clr_req) begin
                    state_d    = S_CLEAR;
                    clr_idx_d  = '0;
                    clr_pend_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                ent_en    = EN_ONE << clr_idx_q;
                ent_op    = OP_CLEAR;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_LAST) begin
                    state_d   = S_IDLE;
                    rr_ptr_d  = '0;
                    clr_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign ent_in_pc     = {1'b0, res_pc_q[15:5]};
    assign ent_in_target = res_target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            clr_idx_q    <= '0;
            clr_pend_q   <= 1'b0;
            res_pc_q     <= '0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            clr_idx_q    <= clr_idx_d;
            clr_pend_q   <= clr_pend_d;
            res_pc_q     <= res_pc_d;
            res_taken_q  <= res_taken_d;
            res_target_q <= res_target_d;
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: the bench plays the entry array by driving
// ent_hit/ent_empty/ent_pred/ent_target and checks the controller's outputs.
module tb_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_pc;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        res_valid, res_ready;
    logic [15:0] res_pc;
    logic        res_taken;
    logic [15:0] res_target;
    logic        clr_req, busy;
    logic [3:0]  ent_en;
    logic [2:0]  ent_op;
    logic [15:0] ent_pc;
    logic [11:0] ent_in_pc;
    logic [15:0] ent_in_target;
    logic [3:0]  ent_hit, ent_pred, ent_empty;
    logic [63:0] ent_target;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_ctrl #(.N_ENTRIES(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target), .clr_req(clr_req), .busy(busy),
        .ent_en(ent_en), .ent_op(ent_op), .ent_pc(ent_pc), .ent_in_pc(ent_in_pc),
        .ent_in_target(ent_in_target), .ent_hit(ent_hit), .ent_pred(ent_pred),
        .ent_target(ent_target), .ent_empty(ent_empty)
    );

    // Present one resolution in S_IDLE, then move to the S_UPDATE cycle with the
    // given entry responses; the res_* inputs are scrambled to prove they were captured.
    task automatic send_res(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                            input logic [3:0] hit, input logic [3:0] empty);
        @(negedge clk);
        res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
        @(negedge clk);
        res_valid = 1'b0; res_pc = 16'hFFFF; res_taken = ~tk; res_target = 16'h0000;
        ent_hit = hit; ent_empty = empty;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr_req = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
        res_target = '0; fetch_pc = '0; ent_hit = '0; ent_pred = '0; ent_target = '0;
        ent_empty = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ent_en !== 4'b0000) begin errors++; $display("FAIL rst_en: got %b want 0000", ent_en); end
        checks++; if (ent_op !== 3'b100) begin errors++; $display("FAIL rst_op: got %b want 100", ent_op); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_pred_hit: got %b want 0", pred_hit); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", res_ready); end
        clr_req = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_clr: got %b want 0", res_ready); end
        clr_req = 1'b0;
    endtask

    task automatic test_insert;
        send_res(16'h0120, 1'b1, 16'h0200, 4'b0000, 4'b1111);
        checks++; if (ent_en !== 4'b0001) begin errors++; $display("FAIL ins_en: got %b want 0001", ent_en); end
        checks++; if (ent_op !== 3'b111) begin errors++; $display("FAIL ins_op: got %b want 111", ent_op); end
        checks++; if (ent_in_pc !== 12'h009) begin errors++; $display("FAIL ins_in_pc: got %h want 009", ent_in_pc); end
        checks++; if (ent_in_target !== 16'h0200) begin errors++; $display("FAIL ins_in_tgt: got %h want 0200", ent_in_target); end
        checks++; if (ent_pc !== 16'h0120) begin errors++; $display("FAIL ins_ent_pc: got %h want 0120", ent_pc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ins_busy: got %b want 1", busy); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL ins_ready_upd: got %b want 0", res_ready); end
        @(negedge clk); #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL ins_ready_after: got %b want 1", res_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ins_busy_after: got %b want 0", busy); end
        checks++; if (ent_en !== 4'b0000) begin errors++; $display("FAIL ins_en_after: got %b want 0000", ent_en); end
        send_res(16'h0A00, 1'b0, 16'h0B00, 4'b0000, 4'b0110);
        checks++; if (ent_en !== 4'b0010) begin errors++; $display("FAIL ins2_en: got %b want 0010", ent_en); end
        checks++; if (ent_op !== 3'b110) begin errors++; $display("FAIL ins2_op: got %b want 110", ent_op); end
        checks++; if (ent_in_pc !== 12'h050) begin errors++; $display("FAIL ins2_in_pc: got %h want 050", ent_in_pc); end
    endtask

    task automatic test_verify;
        ent_target = 64'hBEEF_7777_0040_1234;
        send_res(16'h0120, 1'b0, 16'h0300, 4'b0100, 4'b0000);
        checks++; if (ent_en !== 4'b0100) begin errors++; $display("FAIL vfy_en: got %b want 0100", ent_en); end
        checks++; if (ent_op !== 3'b010) begin errors++; $display("FAIL vfy_op: got %b want 010", ent_op); end
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL vfy_pred_hit: got %b want 0", pred_hit); end
        checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL vfy_pred_tgt: got %h want 0000", pred_target); end
        send_res(16'h2220, 1'b1, 16'h4444, 4'b0110, 4'b1111);
        checks++; if (ent_en !== 4'b0010) begin errors++; $display("FAIL vfy2_en: got %b want 0010", ent_en); end
        checks++; if (ent_op !== 3'b011) begin errors++; $display("FAIL vfy2_op: got %b want 011", ent_op); end
    endtask

    // rr_ptr is 0 here: the inserts used empty entries and verifies leave it alone.
    task automatic test_round_robin;
        logic [1:0] victims [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_en;
        logic [2:0] exp_op;
        for (int k = 0; k < 6; k++) begin
            send_res(16'h1000 + 16'(k * 32), k[0], 16'h2000, 4'b0000, 4'b0000);
            exp_en = 4'b0001 << victims[k];
            exp_op = k[0] ? 3'b111 : 3'b110;
            checks++; if (ent_en !== exp_en) begin errors++; $display("FAIL rr_en[%0d]: got %b want %b", k, ent_en, exp_en); end
            checks++; if (ent_op !== exp_op) begin errors++; $display("FAIL rr_op[%0d]: got %b want %b", k, ent_op, exp_op); end
        end
        send_res(16'h3000, 1'b1, 16'h3100, 4'b0000, 4'b1000);
        checks++; if (ent_en !== 4'b1000) begin errors++; $display("FAIL rr_empty_en: got %b want 1000", ent_en); end
        send_res(16'h3020, 1'b1, 16'h3100, 4'b0000, 4'b0000);
        checks++; if (ent_en !== 4'b0100) begin errors++; $display("FAIL rr_hold_en: got %b want 0100", ent_en); end
    endtask

    task automatic test_predict;
        @(negedge clk);
        fetch_pc = 16'h5678; ent_target = 64'hBEEF_7777_0040_1234;
        ent_hit = 4'b1010; ent_pred = 4'b1010;
        #1;
        checks++; if (ent_pc !== 16'h5678) begin errors++; $display("FAIL prd_ent_pc: got %h want 5678", ent_pc); end
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL prd_hit: got %b want 1", pred_hit); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL prd_taken: got %b want 1", pred_taken); end
        checks++; if (pred_target !== 16'h0040) begin errors++; $display("FAIL prd_tgt: got %h want 0040", pred_target); end
        ent_hit = 4'b1000; ent_pred = 4'b0111;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL prd3_taken: got %b want 0", pred_taken); end
        checks++; if (pred_target !== 16'hBEEF) begin errors++; $display("FAIL prd3_tgt: got %h want BEEF", pred_target); end
        ent_hit = 4'b0110; ent_pred = 4'b0100;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL prd_lo_taken: got %b want 0", pred_taken); end
        checks++; if (pred_target !== 16'h0040) begin errors++; $display("FAIL prd_lo_tgt: got %h want 0040", pred_target); end
        ent_hit = 4'b0000; ent_pred = 4'b1111;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL prd_miss_hit: got %b want 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL prd_miss_taken: got %b want 0", pred_taken); end
    endtask

    task automatic test_clear_collision;
        logic [3:0] exp_en;
        @(negedge clk);
        ent_hit = 4'b0000;
        clr_req = 1'b1; res_valid = 1'b1; res_pc = 16'h0340; res_taken = 1'b1; res_target = 16'h0500;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL col_ready: got %b want 0", res_ready); end
        ent_hit = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) clr_req = 1'b0;
            #1;
            exp_en = 4'b0001 << k;
            checks++; if (ent_op !== 3'b001) begin errors++; $display("FAIL col_op[%0d]: got %b want 001", k, ent_op); end
            checks++; if (ent_en !== exp_en) begin errors++; $display("FAIL col_en[%0d]: got %b want %b", k, ent_en, exp_en); end
            checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL col_pred_hit[%0d]: got %b want 0", k, pred_hit); end
            checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL col_ready[%0d]: got %b want 0", k, res_ready); end
        end
        @(negedge clk);
        ent_hit = 4'b0000;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL col_ready_idle: got %b want 1", res_ready); end
        @(negedge clk);
        res_valid = 1'b0; ent_empty = 4'b1111;
        #1;
        checks++; if (ent_en !== 4'b0001) begin errors++; $display("FAIL col_upd_en: got %b want 0001", ent_en); end
        checks++; if (ent_op !== 3'b111) begin errors++; $display("FAIL col_upd_op: got %b want 111", ent_op); end
        checks++; if (ent_in_pc !== 12'h01A) begin errors++; $display("FAIL col_upd_in_pc: got %h want 01A", ent_in_pc); end
        checks++; if (ent_in_target !== 16'h0500) begin errors++; $display("FAIL col_upd_tgt: got %h want 0500", ent_in_target); end
        // rr_ptr was 3 before the sweep; the sweep must have reset it.
        send_res(16'h7000, 1'b0, 16'h7100, 4'b0000, 4'b0000);
        checks++; if (ent_en !== 4'b0001) begin errors++; $display("FAIL col_rr_en: got %b want 0001", ent_en); end
    endtask

    task automatic test_clear_pending;
        send_res(16'h0800, 1'b1, 16'h0900, 4'b0000, 4'b0000);
        clr_req = 1'b1;
        #1;
        checks++; if (ent_en !== 4'b0010) begin errors++; $display("FAIL pend_upd_en: got %b want 0010", ent_en); end
        checks++; if (ent_op !== 3'b111) begin errors++; $display("FAIL pend_upd_op: got %b want 111", ent_op); end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        checks++; if (ent_op !== 3'b001) begin errors++; $display("FAIL pend_clr_op: got %b want 001", ent_op); end
        checks++; if (ent_en !== 4'b0001) begin errors++; $display("FAIL pend_clr_en: got %b want 0001", ent_en); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ent_en !== 4'b1000) begin errors++; $display("FAIL pend_last_en: got %b want 1000", ent_en); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        clr_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (ent_en !== 4'b1000) begin errors++; $display("FAIL b2b_last_en: got %b want 1000", ent_en); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle_ready: got %b want 0", res_ready); end
        checks++; if (ent_op !== 3'b100) begin errors++; $display("FAIL b2b_idle_op: got %b want 100", ent_op); end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        checks++; if (ent_en !== 4'b0001) begin errors++; $display("FAIL b2b_restart_en: got %b want 0001", ent_en); end
        @(negedge clk); #1;
        checks++; if (ent_en !== 4'b0010) begin errors++; $display("FAIL b2b_sweep1_en: got %b want 0010", ent_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ent_en !== 4'b0000) begin errors++; $display("FAIL b2b_rst_en: got %b want 0000", ent_en); end
        checks++; if (ent_op !== 3'b100) begin errors++; $display("FAIL b2b_rst_op: got %b want 100", ent_op); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_rst_busy: got %b want 0", busy); end
        @(negedge clk); #1;
        checks++; if (ent_en !== 4'b0000) begin errors++; $display("FAIL b2b_rst_hold_en: got %b want 0000", ent_en); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_insert();
        test_verify();
        test_round_robin();
        test_predict();
        test_clear_collision();
        test_clear_pending();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
